// File: rtl/loop_buffer_sync_mblk.sv
// Single-clock, block-granular loop buffer: the producer commits fixed-size blocks, the consumer reads and releases them.
// Optional statistics outputs (ovf_cnt, udf_cnt, max_used) are enabled by defining LOOP_BUF_STATS_EN.

module loop_buffer_sync_mblk #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 4,
    parameter int LOOP_WIDTH   = 6,
    parameter int INFO_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int AFULL_THRESH = 1
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             wr_wen,
    input  logic                             wr_wlast,
    input  logic [INFO_WIDTH-1:0]            wr_info,
    output logic                             wr_rdy,
    output logic [LOOP_WIDTH-ADDR_WIDTH:0]   free_size,
    output logic                             almost_full,

    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic                             rd_ren,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_dvld,
    output logic                             rd_vld,
    output logic [INFO_WIDTH-1:0]            rd_info,
    input  logic                             rd_rdy,

`ifdef LOOP_BUF_STATS_EN
    output logic [15:0]                      ovf_cnt,
    output logic [15:0]                      udf_cnt,
    output logic [LOOP_WIDTH-ADDR_WIDTH:0]   max_used,
`endif
    output logic                             ovf
);

    localparam int BLK_W   = LOOP_WIDTH - ADDR_WIDTH;
    localparam int FS_W    = BLK_W + 1;
    localparam int NUM_BLK = 1 << BLK_W;
    localparam int DEPTH   = 1 << LOOP_WIDTH;

    localparam logic [FS_W-1:0] NUM_BLK_FS = {1'b1, {BLK_W{1'b0}}};
    localparam logic [31:0]     AFULL_U    = 32'(AFULL_THRESH);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("loop_buffer_sync_mblk: READ_LATENCY must be within 1..4");
        end
    endgenerate

    logic [BLK_W-1:0]      wbadr;
    logic [BLK_W-1:0]      rbadr;
    logic                  full;
    logic                  empty;
    logic                  do_commit;
    logic                  do_release;
    logic [FS_W-1:0]       free_next;

    logic [DATA_WIDTH-1:0] mem      [DEPTH];
    logic [INFO_WIDTH-1:0] info_mem [NUM_BLK];

    logic [DATA_WIDTH-1:0]   d_pipe [READ_LATENCY];
    logic [READ_LATENCY-1:0] v_pipe;

    // Flags come only from registered state, so no input reaches them combinationally.
    assign full        = (free_size == '0);
    assign empty       = (free_size == NUM_BLK_FS);
    assign wr_rdy      = !full;
    assign rd_vld      = !empty;
    assign almost_full = (32'(free_size) <= AFULL_U);

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        do_commit  = wr_wlast && !full;
        do_release = rd_rdy && !empty;
        free_next  = free_size;
        unique case ({do_commit, do_release})
            2'b10:   free_next = free_size - 1'b1;
            2'b01:   free_next = free_size + 1'b1;
            default: free_next = free_size;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbadr     <= '0;
            rbadr     <= '0;
            free_size <= NUM_BLK_FS;
            ovf       <= 1'b0;
        end else begin
            free_size <= free_next;
            if (do_commit) begin
                wbadr <= wbadr + 1'b1;
            end
            if (do_release) begin
                rbadr <= rbadr + 1'b1;
            end
            if (wr_wlast && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // NOTE: the data and info arrays carry no reset; their contents are meaningless until a block is committed.
    always_ff @(posedge clk) begin
        if (wr_wen && !full) begin
            mem[{wbadr, wr_addr}] <= wr_data;
        end
        if (do_commit) begin
            info_mem[wbadr] <= wr_info;
        end
    end

    // Sideband reads as zero while nothing is committed, which also gives the zero reset value.
    assign rd_info = rd_vld ? info_mem[rbadr] : '0;

    // Stage 0 samples the array before any same-edge write lands, making the memory read-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                d_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= rd_ren;
            if (rd_ren) begin
                d_pipe[0] <= mem[{rbadr, rd_addr}];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                d_pipe[i] <= d_pipe[i-1];
            end
        end
    end

    assign rd_data = d_pipe[READ_LATENCY-1];
    assign rd_dvld = v_pipe[READ_LATENCY-1];

`ifdef LOOP_BUF_STATS_EN
    logic [FS_W-1:0] used_next;

    assign used_next = NUM_BLK_FS - free_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt  <= '0;
            udf_cnt  <= '0;
            max_used <= '0;
        end else begin
            if (wr_wlast && full && ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
            if (rd_rdy && empty && udf_cnt != 16'hFFFF) begin
                udf_cnt <= udf_cnt + 16'd1;
            end
            if (used_next > max_used) begin
                max_used <= used_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_loop_buffer_sync_mblk.sv
// Directed self-checking bench for loop_buffer_sync_mblk with default parameters (4 blocks of 16 words, latency 2).

module tb_loop_buffer_sync_mblk;

    logic        clk;
    logic        rst;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_wen;
    logic        wr_wlast;
    logic [31:0] wr_info;
    logic        wr_rdy;
    logic [2:0]  free_size;
    logic        almost_full;
    logic [3:0]  rd_addr;
    logic        rd_ren;
    logic [63:0] rd_data;
    logic        rd_dvld;
    logic        rd_vld;
    logic [31:0] rd_info;
    logic        rd_rdy;
    logic        ovf;
`ifdef LOOP_BUF_STATS_EN
    logic [15:0] ovf_cnt;
    logic [15:0] udf_cnt;
    logic [2:0]  max_used;
`endif

    int total = 0;
    int bad   = 0;

    loop_buffer_sync_mblk dut (
        .clk         (clk),
        .rst         (rst),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_wen      (wr_wen),
        .wr_wlast    (wr_wlast),
        .wr_info     (wr_info),
        .wr_rdy      (wr_rdy),
        .free_size   (free_size),
        .almost_full (almost_full),
        .rd_addr     (rd_addr),
        .rd_ren      (rd_ren),
        .rd_data     (rd_data),
        .rd_dvld     (rd_dvld),
        .rd_vld      (rd_vld),
        .rd_info     (rd_info),
        .rd_rdy      (rd_rdy),
`ifdef LOOP_BUF_STATS_EN
        .ovf_cnt     (ovf_cnt),
        .udf_cnt     (udf_cnt),
        .max_used    (max_used),
`endif
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_block(input logic [63:0] base, input logic [31:0] info);
        for (int i = 0; i < 16; i++) begin
            wr_wen   = 1'b1;
            wr_addr  = 4'(i);
            wr_data  = base + 64'(i);
            wr_wlast = (i == 15);
            wr_info  = info;
            step();
        end
        wr_wen   = 1'b0;
        wr_wlast = 1'b0;
    endtask

    task automatic read_word(input logic [3:0] a, output logic [63:0] d, output logic v);
        rd_ren  = 1'b1;
        rd_addr = a;
        step();
        rd_ren  = 1'b0;
        step();
        d = rd_data;
        v = rd_dvld;
    endtask

    logic [63:0] rdat;
    logic        rv;

    initial begin
        rst = 1'b1; wr_addr = '0; wr_data = '0; wr_wen = 1'b0; wr_wlast = 1'b0;
        wr_info = '0; rd_addr = '0; rd_ren = 1'b0; rd_rdy = 1'b0;
        step();
        step();

        // Reset state
        check("rst_free_size", 64'(free_size), 64'd4);
        check("rst_wr_rdy", 64'(wr_rdy), 64'd1);
        check("rst_almost_full", 64'(almost_full), 64'd0);
        check("rst_rd_vld", 64'(rd_vld), 64'd0);
        check("rst_rd_dvld", 64'(rd_dvld), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_rd_info", 64'(rd_info), 64'd0);
        rst = 1'b0;
        step();

        // Block 0: data = offset, commit on the last word with info A5
        for (int i = 0; i < 16; i++) begin
            wr_wen   = 1'b1;
            wr_addr  = 4'(i);
            wr_data  = 64'(i);
            wr_wlast = (i == 15);
            wr_info  = 32'hA5;
            step();
            if (i == 14) check("pre_commit_rd_vld", 64'(rd_vld), 64'd0);
        end
        wr_wen = 1'b0; wr_wlast = 1'b0;
        check("commit_rd_vld", 64'(rd_vld), 64'd1);
        check("commit_rd_info", 64'(rd_info), 64'hA5);
        check("commit_free_size", 64'(free_size), 64'd3);

        // Back-to-back reads of offsets 0..15, two-cycle latency
        for (int j = 0; j < 18; j++) begin
            rd_ren  = (j < 16);
            rd_addr = 4'(j);
            step();
            if (j == 0) check("lat_not_1", 64'(rd_dvld), 64'd0);
            if (j >= 1 && j <= 16) begin
                check("b2b_dvld", 64'(rd_dvld), 64'd1);
                check("b2b_data", rd_data, 64'(j - 1));
            end
        end
        rd_ren = 1'b0;
        check("b2b_dvld_end", 64'(rd_dvld), 64'd0);

        rd_rdy = 1'b1; step(); rd_rdy = 1'b0;
        check("rel0_free_size", 64'(free_size), 64'd4);
        check("rel0_rd_vld", 64'(rd_vld), 64'd0);

        // Fill all four blocks (pointers start at block 1)
        write_block(64'h1000, 32'h100);
        write_block(64'h2000, 32'h101);
        check("af_at_2", 64'(almost_full), 64'd0);
        write_block(64'h3000, 32'h102);
        check("af_at_1", 64'(almost_full), 64'd1);
        write_block(64'h4000, 32'h103);
        check("full_free_size", 64'(free_size), 64'd0);
        check("full_wr_rdy", 64'(wr_rdy), 64'd0);
        check("full_almost_full", 64'(almost_full), 64'd1);
        check("full_ovf_pre", 64'(ovf), 64'd0);

        // Fifth commit attempt while full, writing word 0 of the block under read
        wr_wen = 1'b1; wr_addr = 4'd0; wr_data = 64'hDEAD; wr_wlast = 1'b1; wr_info = 32'hBAD;
        step();
        wr_wen = 1'b0; wr_wlast = 1'b0;
        check("ovf_set", 64'(ovf), 64'd1);
        check("ovf_free_size", 64'(free_size), 64'd0);
        check("ovf_rd_info", 64'(rd_info), 64'h100);
`ifdef LOOP_BUF_STATS_EN
        check("ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
        read_word(4'd0, rdat, rv);
        check("ovf_mem_w0_dvld", 64'(rv), 64'd1);
        check("ovf_mem_w0", rdat, 64'h1000);
        read_word(4'd5, rdat, rv);
        check("ovf_mem_w5", rdat, 64'h1005);

        // Release while full, then simultaneous commit and release at free_size 2
        rd_rdy = 1'b1; step(); rd_rdy = 1'b0;
        check("rel_full_wr_rdy", 64'(wr_rdy), 64'd1);
        check("rel_full_free", 64'(free_size), 64'd1);
        rd_rdy = 1'b1; step(); rd_rdy = 1'b0;
        check("free2", 64'(free_size), 64'd2);
        check("free2_af", 64'(almost_full), 64'd0);
        check("free2_info", 64'(rd_info), 64'h102);
        wr_wlast = 1'b1; wr_info = 32'h55; rd_rdy = 1'b1;
        step();
        wr_wlast = 1'b0; rd_rdy = 1'b0;
        check("both_free", 64'(free_size), 64'd2);
        check("both_rd_info", 64'(rd_info), 64'h103);
        rd_rdy = 1'b1; step();
        check("both_wr_info", 64'(rd_info), 64'h55);
        step(); rd_rdy = 1'b0;
        check("drain_free", 64'(free_size), 64'd4);
        check("drain_rd_vld", 64'(rd_vld), 64'd0);

        // Ten commit/release rounds, info = round index, pointers wrap
        for (int k = 0; k < 10; k++) begin
            wr_wlast = 1'b1; wr_info = 32'(k);
            step();
            wr_wlast = 1'b0;
            check("wrap_rd_info", 64'(rd_info), 64'(k));
            check("wrap_free", 64'(free_size), 64'd3);
            rd_rdy = 1'b1; step(); rd_rdy = 1'b0;
        end
        check("wrap_end_free", 64'(free_size), 64'd4);

        // Release attempt while empty
        rd_rdy = 1'b1; step(); rd_rdy = 1'b0;
        check("udf_free", 64'(free_size), 64'd4);
        check("udf_rd_vld", 64'(rd_vld), 64'd0);
`ifdef LOOP_BUF_STATS_EN
        check("udf_cnt", 64'(udf_cnt), 64'd1);
        check("max_used", 64'(max_used), 64'd4);
`endif
        wr_wlast = 1'b1; wr_info = 32'h77; step(); wr_wlast = 1'b0;
        check("udf_rbadr_same", 64'(rd_info), 64'h77);

        // Reset with reads in flight
        rd_ren = 1'b1; rd_addr = 4'd0;
        step();
        step();
        check("inflight_dvld", 64'(rd_dvld), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_dvld", 64'(rd_dvld), 64'd0);
        check("mid_rst_free", 64'(free_size), 64'd4);
        check("mid_rst_rd_vld", 64'(rd_vld), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        check("mid_rst_data", rd_data, 64'd0);
`ifdef LOOP_BUF_STATS_EN
        check("mid_rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
        rd_ren = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        check("post_rst_dvld", 64'(rd_dvld), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
